axis_dac_prbs_burst: RTL and testbench
======================================

Name: axis_dac_prbs_burst

Overview:
Multi-channel DAC sample generator and formatter.
- Per channel, selects one of: streamed AXIS samples, PRBS BPSK chips, burst-marker square wave, or mid-scale.
- Generates the PRBS from a programmable Fibonacci LFSR, clocked at a divided chip rate and gated by a burst/gap sequencer.
- Drives the registered, DAC-coded sample bus that feeds the ODDR output stage one level up.

Parameters:
- DAC_DATA_WIDTH, 14: DAC code width per channel.
- CHANNELS, 2: number of DAC channels.
- AXIS_TDATA_WIDTH, 32: input stream width; must equal 16*CHANNELS. Channel k uses lane bits [16k+DAC_DATA_WIDTH-1:16k].
- LFSR_WIDTH, 16: PRBS register length, 2..32.

Ports:
- aclk, in, 1: sole clock.
- aresetn, in, 1: reset, synchronous, active-low.
- s_axis_tdata, in, AXIS_TDATA_WIDTH: two's-complement samples, one lane per channel.
- s_axis_tvalid, in, 1: stream valid.
- s_axis_tready, out, 1: stream ready.
- cfg_mode, in, 2*CHANNELS: per-channel mode. Bits [2k+1:2k] belong to channel k.
- cfg_amp, in, DAC_DATA_WIDTH-1: unsigned modulation magnitude A.
- cfg_div, in, 8: chip period minus 1, in aclk cycles.
- cfg_burst_len, in, 16: chips per burst. 0 selects continuous operation.
- cfg_gap_len, in, 16: idle cycles between bursts.
- cfg_seed, in, LFSR_WIDTH: LFSR seed.
- cfg_taps, in, LFSR_WIDTH: LFSR feedback mask.
- cfg_start, in, 1: start pulse.
- cfg_stop, in, 1: stop pulse.
- dac_dat_o, out, CHANNELS*DAC_DATA_WIDTH: DAC codes, one field per channel.
- tx_flag_o, out, 1: high during PAYLOAD.
- busy_o, out, 1: state is not IDLE.

Behaviour:
- Code conversion. For a signed value s of DAC_DATA_WIDTH bits, code = {s[W-1], ~s[W-2:0]}, so +max maps to all-zeros and 0 maps to 0x1FFF (W=14). "Mid" means the code of s=0.
- Reset (aresetn low at an aclk edge):
  - state IDLE;
  - tx_flag_o=0, busy_o=0;
  - every dac_dat_o field = mid;
  - LFSR = all-ones;
  - all counters = 0.
- s_axis_tready is constant 1. The input stream is never back-pressured.
- Latching. cfg_div, cfg_burst_len, cfg_gap_len, cfg_taps and cfg_seed are captured on the accepted start. cfg_mode and cfg_amp are used live.
- State machine: IDLE, PAYLOAD, GAP.
  - IDLE, cfg_start=1: latch configuration, load LFSR from seed, clear the divider and chip counters, enter PAYLOAD.
  - PAYLOAD: the divider counts 0..div. A chip strobe occurs on the cycle the divider equals div; div=0 gives a strobe every cycle.
    - On each strobe the LFSR shifts left: new LSB = XOR-reduce(lfsr & taps).
    - On each strobe the chip counter increments.
    - The chip bit is LFSR[MSB] and is held between strobes.
  - PAYLOAD exit: on the strobe where chip count = burst_len-1, go to GAP, unless burst_len = 0 (stay in PAYLOAD indefinitely).
  - gap_len = 0: the FSM re-enters PAYLOAD directly, with a reseed.
  - GAP: counts gap_len cycles, then enters PAYLOAD, reloads the seed and clears the counters. Every burst repeats the same sequence.
  - cfg_stop: from any state, go to IDLE on the next edge. Stop has priority over a simultaneous start.
  - cfg_start outside IDLE is ignored.
- Zero seed guard: an all-zero seed (or all-zero LFSR at load) loads all-ones instead, to avoid lock-up.
- tx_flag_o = (state==PAYLOAD), registered. busy_o = (state!=IDLE), registered.
- Channel modes (output is registered; latency 1 cycle from state/LFSR/input to dac_dat_o):
  - 00 passthrough: if s_axis_tvalid, output code(lane). Otherwise output mid.
  - 01 PRBS BPSK: in PAYLOAD, output code(+A) when chip=1 and code(-A) when chip=0. Outside PAYLOAD, output mid.
  - 10 marker: output code(+A) in PAYLOAD, code(-A) otherwise (including IDLE).
  - 11 mid, constant.
- Amplitude. ±A is formed at DAC_DATA_WIDTH bits; no overflow is possible because A ≤ 2^(W-1)-1. A=0 yields mid.
- Reset mid-burst aborts immediately with the reset values. No partial state survives.

Test Plan:
- Reset: aresetn=0 for 3 cycles with random inputs → every dac_dat_o field = 0x1FFF, tx_flag_o=0, busy_o=0.
- Passthrough:
  - ch0=0x1FFF, ch1=0xE000, tvalid=1, mode 00 → one cycle later ch0 code 0x0000, ch1 code 0x3FFF.
  - tvalid=0 → both fields 0x1FFF.
- PRBS:
  - Setup: seed=0x0001, taps=0xB400 (LFSR_WIDTH=16), div=0, burst_len=0, A=0x1FFF, mode 01.
  - Required: chips match the reference model every cycle, with values 0x0000/0x3FFE only.
  - Sequence period: 65535 chips.
  - tx_flag_o stays 1.
- Burst timing:
  - Setup: div=3, burst_len=5, gap_len=7, seed=0xACE1.
  - Required: tx_flag_o high for 20 cycles, then low for 7, then high again.
  - The second burst's chip sequence is identical to the first.
- Control pulses:
  - Stop+start on the same cycle in PAYLOAD → IDLE next cycle, busy_o=0, mode-10 channel = code(-A).
  - Start while in GAP → ignored.
- Edge configuration:
  - seed=0 → behaves as seed 0xFFFF.
  - gap_len=0 with burst_len=2, div=0 → tx_flag_o constantly 1, LFSR reseeded every 2 chips.
  - aresetn pulled low mid-burst → reset values on the next edge.

Source files
------------

// File: rtl/axis_dac_prbs_burst.sv
// Multi-channel DAC sample generator: AXIS passthrough, PRBS BPSK,
// burst marker or mid-scale per channel, with a burst/gap sequencer.
module axis_dac_prbs_burst #(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int CHANNELS         = 2,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LFSR_WIDTH       = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [2*CHANNELS-1:0]              cfg_mode,
  input  logic [DAC_DATA_WIDTH-2:0]          cfg_amp,
  input  logic [7:0]                         cfg_div,
  input  logic [15:0]                        cfg_burst_len,
  input  logic [15:0]                        cfg_gap_len,
  input  logic [LFSR_WIDTH-1:0]              cfg_seed,
  input  logic [LFSR_WIDTH-1:0]              cfg_taps,
  input  logic                               cfg_start,
  input  logic                               cfg_stop,
  output logic [CHANNELS*DAC_DATA_WIDTH-1:0] dac_dat_o,
  output logic                               tx_flag_o,
  output logic                               busy_o
);

  localparam int W = DAC_DATA_WIDTH;
  localparam logic [W-1:0] MID = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t                  state;
  logic [LFSR_WIDTH-1:0]   lfsr;
  logic [LFSR_WIDTH-1:0]   seed_l;
  logic [LFSR_WIDTH-1:0]   taps_l;
  logic [7:0]              div_l;
  logic [7:0]              div_cnt;
  logic [15:0]             burst_l;
  logic [15:0]             gap_l;
  logic [15:0]             chip_cnt;
  logic [15:0]             gap_cnt;

  logic                    strobe;
  logic                    last_chip;
  logic                    gap_done;
  logic                    fb;
  logic [LFSR_WIDTH-1:0]   start_seed;
  logic [W-1:0]            pos_a;
  logic [W-1:0]            neg_a;
  logic [W-1:0]            code_pos;
  logic [W-1:0]            code_neg;
  logic [CHANNELS*W-1:0]   dac_nxt;
  logic                    unused_ok;

  function automatic logic [W-1:0] to_code(input logic [W-1:0] s);
    return {s[W-1], ~s[W-2:0]};
  endfunction

  assign s_axis_tready = 1'b1;
  assign unused_ok     = ^s_axis_tdata;

  assign strobe    = (div_cnt == div_l);
  assign last_chip = (burst_l != 16'd0) &&
                     (chip_cnt == burst_l - 16'd1);
  assign gap_done  = (gap_cnt == gap_l - 16'd1);
  assign fb        = ^(lfsr & taps_l);

  // An all-zero LFSR never leaves zero, so load all-ones instead.
  assign start_seed = (cfg_seed == '0) ? '1 : cfg_seed;

  assign pos_a    = {1'b0, cfg_amp};
  assign neg_a    = -pos_a;
  assign code_pos = to_code(pos_a);
  assign code_neg = to_code(neg_a);

  always_comb begin
    dac_nxt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (cfg_mode[2*k +: 2])
        2'b00:
          dac_nxt[k*W +: W] = s_axis_tvalid ?
            to_code(s_axis_tdata[16*k +: W]) : MID;
        2'b01:
          dac_nxt[k*W +: W] = (state != S_PAYLOAD) ? MID :
            (lfsr[LFSR_WIDTH-1] ? code_pos : code_neg);
        2'b10:
          dac_nxt[k*W +: W] = (state == S_PAYLOAD) ?
            code_pos : code_neg;
        default:
          dac_nxt[k*W +: W] = MID;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      lfsr      <= '1;
      seed_l    <= '1;
      taps_l    <= '0;
      div_l     <= '0;
      div_cnt   <= '0;
      burst_l   <= '0;
      gap_l     <= '0;
      chip_cnt  <= '0;
      gap_cnt   <= '0;
      tx_flag_o <= 1'b0;
      busy_o    <= 1'b0;
      dac_dat_o <= {CHANNELS{MID}};
    end else begin
      tx_flag_o <= (state == S_PAYLOAD);
      busy_o    <= (state != S_IDLE);
      dac_dat_o <= dac_nxt;
      if (cfg_stop) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cfg_start) begin
              div_l    <= cfg_div;
              burst_l  <= cfg_burst_len;
              gap_l    <= cfg_gap_len;
              taps_l   <= cfg_taps;
              seed_l   <= start_seed;
              lfsr     <= start_seed;
              div_cnt  <= '0;
              chip_cnt <= '0;
              state    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (strobe) begin
              div_cnt  <= '0;
              chip_cnt <= chip_cnt + 16'd1;
              lfsr     <= {lfsr[LFSR_WIDTH-2:0], fb};
              if (last_chip) begin
                if (gap_l == 16'd0) begin
                  lfsr     <= seed_l;
                  chip_cnt <= '0;
                end else begin
                  gap_cnt <= '0;
                  state   <= S_GAP;
                end
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          S_GAP: begin
            if (gap_done) begin
              lfsr     <= seed_l;
              div_cnt  <= '0;
              chip_cnt <= '0;
              state    <= S_PAYLOAD;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_dac_prbs_burst.sv
// Bench for axis_dac_prbs_burst: vector table, directed sequences
// and randomized traffic against a timeline-based reference model.
module tb_axis_dac_prbs_burst;

  localparam int W  = 14;
  localparam int CH = 2;
  localparam int TW = 32;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [TW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic [2*CH-1:0] mode;
  logic [W-2:0]  amp;
  logic [7:0]    div;
  logic [15:0]   bl;
  logic [15:0]   gl;
  logic [LW-1:0] seed;
  logic [LW-1:0] taps;
  logic          start;
  logic          stop;
  logic [CH*W-1:0] dac;
  logic          tx;
  logic          busy;

  axis_dac_prbs_burst #(
    .DAC_DATA_WIDTH(W), .CHANNELS(CH),
    .AXIS_TDATA_WIDTH(TW), .LFSR_WIDTH(LW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .cfg_mode(mode), .cfg_amp(amp), .cfg_div(div),
    .cfg_burst_len(bl), .cfg_gap_len(gl),
    .cfg_seed(seed), .cfg_taps(taps),
    .cfg_start(start), .cfg_stop(stop),
    .dac_dat_o(dac), .tx_flag_o(tx), .busy_o(busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: position on the burst timeline since start.
  bit            run;
  int            n;
  int            m_div, m_bl, m_gl;
  logic [LW-1:0] m_lfsr, m_taps;
  bit            chips[$];

  function automatic logic [W-1:0] code(input int s);
    int v;
    v = ((1 << (W-1)) - 1 - s) & ((1 << W) - 1);
    return v[W-1:0];
  endfunction

  function automatic bit get_chip(input int i);
    while (chips.size() <= i) begin
      chips.push_back(m_lfsr[LW-1]);
      m_lfsr = {m_lfsr[LW-2:0], ^(m_lfsr & m_taps)};
    end
    return chips[i];
  endfunction

  task automatic phase(output bit pay, output int ci);
    int dl, p, m;
    pay = 0;
    ci  = 0;
    dl  = m_div + 1;
    if (!run) return;
    if (m_bl == 0) begin
      pay = 1;
      ci  = n / dl;
    end else begin
      p = m_bl * dl + m_gl;
      m = n % p;
      if (m < m_bl * dl) begin
        pay = 1;
        ci  = m / dl;
      end
    end
  endtask

  task automatic cycle();
    logic [CH*W-1:0] e_dac;
    bit   e_tx, e_busy, pay, chip;
    int   ci, s, a;
    phase(pay, ci);
    chip = pay ? get_chip(ci) : 1'b0;
    a = int'(amp);
    e_dac = '0;
    for (int k = 0; k < CH; k++) begin
      case (mode[2*k +: 2])
        2'b00: begin
          s = int'(tdata[16*k +: W]);
          if (s >= (1 << (W-1))) s -= (1 << W);
          e_dac[k*W +: W] = tvalid ? code(s) : code(0);
        end
        2'b01: e_dac[k*W +: W] = !pay ? code(0) :
                                 (chip ? code(a) : code(-a));
        2'b10: e_dac[k*W +: W] = pay ? code(a) : code(-a);
        default: e_dac[k*W +: W] = code(0);
      endcase
    end
    e_tx   = run && pay;
    e_busy = run;
    if (!aresetn) begin
      e_dac  = {CH{code(0)}};
      e_tx   = 0;
      e_busy = 0;
    end
    @(posedge aclk);
    #1;
    chk("dac", dac, e_dac);
    chk("tx_flag", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("tready", tready, 1'b1);
    if (!aresetn || stop) begin
      run = 0;
    end else if (run) begin
      n++;
    end else if (start) begin
      run    = 1;
      n      = 0;
      m_div  = int'(div);
      m_bl   = int'(bl);
      m_gl   = int'(gl);
      m_taps = taps;
      m_lfsr = (seed == '0) ? '1 : seed;
      chips.delete();
    end
  endtask

  task automatic pulse_start();
    start = 1;
    cycle();
    start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1;
    cycle();
    stop = 0;
  endtask

  typedef struct {
    logic [3:0]  mode;
    logic [31:0] tdata;
    logic        tvalid;
    logic [12:0] amp;
    logic [13:0] e0;
    logic [13:0] e1;
  } vec_t;

  vec_t tbl[7];
  bit   txq[100];

  initial begin
    int hi, lo, bad, tlow;
    logic [W-1:0] f0, f1;

    tbl[0] = '{4'b0000, 32'hE000_1FFF, 1'b1, 13'h1FFF, 14'h0000, 14'h3FFF};
    tbl[1] = '{4'b0000, 32'hE000_1FFF, 1'b0, 13'h1FFF, 14'h1FFF, 14'h1FFF};
    tbl[2] = '{4'b0101, 32'h1234_5678, 1'b1, 13'h1FFF, 14'h1FFF, 14'h1FFF};
    tbl[3] = '{4'b1010, 32'h1234_5678, 1'b1, 13'h1FFF, 14'h3FFE, 14'h3FFE};
    tbl[4] = '{4'b1111, 32'h1234_5678, 1'b1, 13'h0ABC, 14'h1FFF, 14'h1FFF};
    tbl[5] = '{4'b1000, 32'h0000_0001, 1'b1, 13'h0000, 14'h1FFE, 14'h1FFF};
    tbl[6] = '{4'b0010, 32'h7FFF_0000, 1'b1, 13'h0005, 14'h2004, 14'h2000};

    run = 0; n = 0;
    aresetn = 0; start = 0; stop = 0;
    div = 0; bl = 0; gl = 0; seed = 0; taps = 0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      tdata = $urandom; tvalid = 1'($urandom);
      mode = 4'($urandom); amp = 13'($urandom);
      cycle();
    end
    chk("rst_dac", dac, {2{14'h1FFF}});
    chk("rst_tx", tx, 1'b0);
    chk("rst_busy", busy, 1'b0);
    aresetn = 1;

    // Vector table, FSM idle
    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode; tdata = tbl[i].tdata;
      tvalid = tbl[i].tvalid; amp = tbl[i].amp;
      cycle();
      f0 = dac[0 +: W];
      f1 = dac[W +: W];
      chk($sformatf("vec%0d_ch0", i), f0, tbl[i].e0);
      chk($sformatf("vec%0d_ch1", i), f1, tbl[i].e1);
    end

    // PRBS continuous over a full period
    seed = 16'h0001; taps = 16'hB400; div = 0; bl = 0; gl = 0;
    amp = 13'h1FFF; mode = 4'b0101; tvalid = 1;
    pulse_start();
    bad = 0; tlow = 0;
    for (int i = 0; i < 65535 + 40; i++) begin
      tdata = $urandom;
      cycle();
      f0 = dac[0 +: W];
      f1 = dac[W +: W];
      if (!(f0 == 14'h0000 || f0 == 14'h3FFE)) bad++;
      if (f1 != f0) bad++;
      if (!tx) tlow++;
    end
    chk("prbs_levels", bad, 0);
    chk("prbs_tx_low", tlow, 0);
    pulse_stop();
    cycle();

    // Burst timing
    div = 3; bl = 5; gl = 7; seed = 16'hACE1;
    amp = 13'h0123; mode = 4'b1001;
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      cycle();
      txq[i] = tx;
    end
    hi = 0;
    while (hi < 60 && txq[hi]) hi++;
    lo = 0;
    while (hi + lo < 60 && !txq[hi+lo]) lo++;
    chk("burst_high", hi, 20);
    chk("burst_gap", lo, 7);
    chk("burst2_tx", txq[27], 1'b1);

    // Stop + start together in PAYLOAD; mode-10 channel goes to -A
    for (int i = 0; i < 30; i++) cycle();
    while (!tx) cycle();
    stop = 1; start = 1;
    cycle();
    stop = 0; start = 0;
    cycle();
    f1 = dac[W +: W];
    chk("stop_busy", busy, 1'b0);
    chk("stop_tx", tx, 1'b0);
    chk("stop_marker", f1, code(-int'(amp)));

    // Start inside GAP is ignored: gap stays 10 cycles
    div = 0; bl = 2; gl = 10; seed = 16'h1357;
    pulse_start();
    for (int i = 0; i < 25; i++) begin
      if (i == 5) start = 1;
      cycle();
      start = 0;
      txq[i] = tx;
    end
    lo = 0;
    for (int i = 2; i < 25 && !txq[i]; i++) lo++;
    chk("gap_start_ignored", lo, 10);
    pulse_stop();

    // Zero seed behaves as all-ones
    seed = 0; taps = 16'hB400; div = 0; bl = 0; gl = 0;
    amp = 13'h0100; mode = 4'b0101;
    pulse_start();
    cycle();
    f0 = dac[0 +: W];
    chk("seed0_first_chip", f0, code(256));
    for (int i = 0; i < 40; i++) cycle();
    pulse_stop();

    // gap_len 0: continuous payload with reseed every 2 chips
    seed = 16'hACE1; bl = 2; gl = 0; div = 0;
    pulse_start();
    tlow = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (!tx) tlow++;
    end
    chk("gap0_tx_low", tlow, 0);

    // Reset mid-burst
    aresetn = 0;
    cycle();
    chk("rst_mid_dac", dac, {2{14'h1FFF}});
    chk("rst_mid_tx", tx, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    aresetn = 1;
    for (int i = 0; i < 5; i++) cycle();

    // Randomized configurations and traffic
    for (int r = 0; r < 6; r++) begin
      div  = 8'($urandom_range(0, 3));
      bl   = 16'($urandom_range(0, 6));
      gl   = 16'($urandom_range(0, 5));
      seed = 16'($urandom);
      if (r == 2) seed = 0;
      taps = 16'($urandom);
      for (int i = 0; i < 600; i++) begin
        tdata  = $urandom;
        tvalid = 1'($urandom);
        mode   = 4'($urandom);
        amp    = 13'($urandom);
        start  = ($urandom_range(0, 15) == 0);
        stop   = ($urandom_range(0, 79) == 0);
        aresetn = ($urandom_range(0, 299) != 0);
        cycle();
      end
      start = 0; stop = 0; aresetn = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
